// File: rtl/tm1638_pkg.sv
// Shared TM1638 definitions: bus command bytes, reader state encoding and
// the mapping from raw scan bits to the eight front-panel keys.
package tm1638_pkg;

  localparam logic [7:0] CMD_READ_KEYS  = 8'h42;
  localparam logic [7:0] CMD_WRITE_AUTO = 8'h40;
  localparam logic [7:0] CMD_DISP_ON    = 8'h8F;

  localparam int SCAN_BITS = 32;
  localparam int KEY_COUNT = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_CMD   = 3'd2,
    ST_WAIT  = 3'd3,
    ST_READ  = 3'd4,
    ST_HOLD  = 3'd5,
    ST_DONE  = 3'd6
  } readState_t;

  // Keys 0..3 sit on bit 0 of scan bytes 0..3, keys 4..7 on bit 4 of the same bytes.
  function automatic logic [KEY_COUNT-1:0] keyMap(input logic [SCAN_BITS-1:0] scanWord);
    logic [KEY_COUNT-1:0] keyBits;
    keyBits = '0;
    for (int i = 0; i < KEY_COUNT; i++) begin
      if (i < 4) keyBits[i] = scanWord[8*i];
      else       keyBits[i] = scanWord[8*(i-4)+4];
    end
    return keyBits;
  endfunction

endpackage

// File: rtl/tm1638_half_tick.sv
// SCLK half-period timer shared by the TM1638 reader and writer.
// Counts 0..CLK_DIV-1 while enabled and flags the last count as a tick.
module tm1638_half_tick #(
  parameter int CLK_DIV = 25
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clear,
  input  logic i_en,
  output logic o_tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST_COUNT = CW'(CLK_DIV - 1);

  logic [CW-1:0] r_count;

  assign o_tick = i_en && !i_clear && (r_count == LAST_COUNT);

  // Free-running half-period count, restarted by clear and wrapped on each tick.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= o_tick ? '0 : r_count + CW'(1);
    end
  end

endmodule

// File: rtl/tm1638_key_reader.sv
// TM1638 key-scan reader: frames STB, sends the read command LSB first,
// turns DIO around, clocks in 32 scan bits and publishes scan word and keys.
module tm1638_key_reader
  import tm1638_pkg::*;
#(
  parameter int CLK_DIV     = 25,
  parameter int WAIT_CYCLES = 50
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_stb_n,
  output logic        o_sclk,
  output logic        o_dio_out,
  output logic        o_dio_oe,
  input  logic        i_dio_in,
  output logic [31:0] o_scan,
  output logic [7:0]  o_keys
);

  localparam int WW = $clog2(WAIT_CYCLES + 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(WAIT_CYCLES - 1);

  readState_t           r_state;
  logic [4:0]           r_bitCnt;
  logic                 r_phase;
  logic [WW-1:0]        r_waitCnt;
  logic [SCAN_BITS-1:0] r_shift;
  logic                 r_dioMeta;
  logic                 r_dioSync;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_stbN;
  logic                 r_sclk;
  logic                 r_dioOut;
  logic                 r_dioOe;
  logic [SCAN_BITS-1:0] r_scan;
  logic [KEY_COUNT-1:0] r_keys;

  logic                 w_tmrClear;
  logic                 w_tick;
  logic [2:0]           w_nextCmdIdx;

  assign o_busy    = r_busy;
  assign o_done    = r_done;
  assign o_stb_n   = r_stbN;
  assign o_sclk    = r_sclk;
  assign o_dio_out = r_dioOut;
  assign o_dio_oe  = r_dioOe;
  assign o_scan    = r_scan;
  assign o_keys    = r_keys;

  // The timer only runs in the SCLK-paced states; every one of them is entered
  // either from a cleared timer or on a tick, so each starts from count zero.
  assign w_tmrClear   = (r_state == ST_IDLE) || (r_state == ST_WAIT) || (r_state == ST_DONE);
  assign w_nextCmdIdx = r_bitCnt[2:0] + 3'd1;

  tm1638_half_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_halfTick (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clear (w_tmrClear),
    .i_en    (!w_tmrClear),
    .o_tick  (w_tick)
  );

  // Two-flop synchronizer for the asynchronous DIO pin.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_dioMeta <= 1'b1;
      r_dioSync <= 1'b1;
    end else begin
      r_dioMeta <= i_dio_in;
      r_dioSync <= r_dioMeta;
    end
  end

  // Transaction sequencer with registered bus pins and the scan shift register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= ST_IDLE;
      r_bitCnt  <= '0;
      r_phase   <= 1'b0;
      r_waitCnt <= '0;
      r_shift   <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_stbN    <= 1'b1;
      r_sclk    <= 1'b1;
      r_dioOut  <= 1'b1;
      r_dioOe   <= 1'b0;
      r_scan    <= '0;
      r_keys    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          r_busy <= 1'b0;
          if (i_start && !r_busy) begin
            r_busy   <= 1'b1;
            r_stbN   <= 1'b0;
            r_dioOe  <= 1'b1;
            r_dioOut <= 1'b1;
            r_sclk   <= 1'b1;
            r_shift  <= '0;
            r_state  <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (w_tick) begin
            r_sclk   <= 1'b0;
            r_dioOut <= CMD_READ_KEYS[0];
            r_bitCnt <= '0;
            r_phase  <= 1'b0;
            r_state  <= ST_CMD;
          end
        end
        ST_CMD: begin
          if (w_tick) begin
            if (!r_phase) begin
              r_sclk  <= 1'b1;
              r_phase <= 1'b1;
            end else if (r_bitCnt == 5'd7) begin
              r_dioOe   <= 1'b0;
              r_dioOut  <= 1'b1;
              r_waitCnt <= '0;
              r_state   <= ST_WAIT;
            end else begin
              r_bitCnt <= r_bitCnt + 5'd1;
              r_sclk   <= 1'b0;
              r_phase  <= 1'b0;
              r_dioOut <= CMD_READ_KEYS[w_nextCmdIdx];
            end
          end
        end
        ST_WAIT: begin
          if (r_waitCnt == WAIT_LAST) begin
            r_sclk   <= 1'b0;
            r_phase  <= 1'b0;
            r_bitCnt <= '0;
            r_state  <= ST_READ;
          end else begin
            r_waitCnt <= r_waitCnt + WW'(1);
          end
        end
        ST_READ: begin
          if (w_tick) begin
            if (!r_phase) begin
              r_sclk  <= 1'b1;
              r_phase <= 1'b1;
            end else begin
              r_shift[r_bitCnt] <= r_dioSync;
              if (r_bitCnt == 5'd31) begin
                r_state <= ST_HOLD;
              end else begin
                r_bitCnt <= r_bitCnt + 5'd1;
                r_sclk   <= 1'b0;
                r_phase  <= 1'b0;
              end
            end
          end
        end
        ST_HOLD: begin
          if (w_tick) begin
            r_stbN  <= 1'b1;
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_scan  <= r_shift;
          r_keys  <= keyMap(r_shift);
          r_done  <= 1'b1;
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tm1638_key_reader.sv
// Bench for the TM1638 key reader: a behavioural TM1638 answers the scan,
// a scoreboard queues the expected command bits and scan results.
module tb_tm1638_key_reader;

  localparam int CLK_DIV       = 2;
  localparam int WAIT_CYCLES   = 4;
  localparam int BUSY_EXPECTED = CLK_DIV * 82 + WAIT_CYCLES + 2;
  localparam int DONE_BUDGET   = 400;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_start = 1'b0;
  logic        i_dio_in = 1'b1;
  logic        o_busy;
  logic        o_done;
  logic        o_stb_n;
  logic        o_sclk;
  logic        o_dio_out;
  logic        o_dio_oe;
  logic [31:0] o_scan;
  logic [7:0]  o_keys;

  int checks = 0;
  int errors = 0;

  logic        cmdQ[$];
  logic [31:0] scanQ[$];
  logic [7:0]  keysQ[$];

  int   doneCount = 0;
  int   busyCycles = 0;
  int   stbRises = 0;
  int   cmdBitsSeen = 0;
  logic prevSclk = 1'b1;
  logic prevStb = 1'b1;

  logic [31:0] modelData = 32'h0;
  int          modelIdx = 0;
  logic        modelDriving = 1'b0;

  tm1638_key_reader #(
    .CLK_DIV     (CLK_DIV),
    .WAIT_CYCLES (WAIT_CYCLES)
  ) dut (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_start   (i_start),
    .o_busy    (o_busy),
    .o_done    (o_done),
    .o_stb_n   (o_stb_n),
    .o_sclk    (o_sclk),
    .o_dio_out (o_dio_out),
    .o_dio_oe  (o_dio_oe),
    .i_dio_in  (i_dio_in),
    .o_scan    (o_scan),
    .o_keys    (o_keys)
  );

  // 100 MHz-style free-running clock.
  always #5 i_clk = ~i_clk;

  // TM1638 model: presents the next scan bit on each SCLK fall once DIO is released.
  always @(negedge o_sclk or posedge o_stb_n) begin
    if (o_stb_n) begin
      modelIdx     = 0;
      modelDriving = 1'b0;
      i_dio_in     = 1'b1;
    end else if (!o_dio_oe && modelIdx < 32) begin
      i_dio_in     = modelData[modelIdx];
      modelIdx     = modelIdx + 1;
      modelDriving = 1'b1;
    end
  end

  function automatic logic [7:0] refKeys(input logic [31:0] s);
    return {s[28], s[20], s[12], s[4], s[24], s[16], s[8], s[0]};
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Advance one clock and observe the bus at the falling edge.
  task automatic stepCycle();
    logic expBit;
    logic [31:0] expScan;
    logic [7:0] expKeys;
    @(negedge i_clk);
    if (o_busy === 1'b1) busyCycles++;
    if (o_sclk === 1'b1 && prevSclk === 1'b0 && o_dio_oe === 1'b1) begin
      cmdBitsSeen++;
      if (cmdQ.size() > 0) begin
        expBit = cmdQ.pop_front();
        checkOutput("cmd_bit", 64'(o_dio_out), 64'(expBit));
        checkOutput("stb_low_at_cmd_bit", 64'(o_stb_n), 64'd0);
      end
    end
    if (o_stb_n === 1'b1 && prevStb === 1'b0) stbRises++;
    if (o_done === 1'b1) begin
      doneCount++;
      if (scanQ.size() > 0) begin
        expScan = scanQ.pop_front();
        expKeys = keysQ.pop_front();
        checkOutput("scan_word", 64'(o_scan), 64'(expScan));
        checkOutput("keys", 64'(o_keys), 64'(expKeys));
      end
    end
    if (modelDriving) checkOutput("bus_contention_oe", 64'(o_dio_oe), 64'd0);
    prevSclk = o_sclk;
    prevStb  = o_stb_n;
  endtask

  task automatic applyStimulus(input logic [31:0] response, input bit expectDone);
    logic [7:0] cmdWord;
    cmdWord = 8'h42;
    modelData   = response;
    busyCycles  = 0;
    doneCount   = 0;
    stbRises    = 0;
    cmdBitsSeen = 0;
    for (int b = 0; b < 8; b++) cmdQ.push_back(cmdWord[b]);
    if (expectDone) begin
      scanQ.push_back(response);
      keysQ.push_back(refKeys(response));
    end
    i_start = 1'b1;
    stepCycle();
    i_start = 1'b0;
  endtask

  task automatic waitDone(input int startPulseAt, input bit startOnDone);
    int n;
    bit seen;
    n = 0;
    seen = 1'b0;
    while (!seen && n < DONE_BUDGET) begin
      if (n == startPulseAt) i_start = 1'b1;
      stepCycle();
      i_start = 1'b0;
      n++;
      if (doneCount > 0) seen = 1'b1;
    end
    checkOutput("done_seen_within_budget", 64'(seen), 64'd1);
    if (startOnDone && seen) i_start = 1'b1;
    stepCycle();
    i_start = 1'b0;
    checkOutput("busy_cleared_after_done", 64'(o_busy), 64'd0);
  endtask

  task automatic checkTransaction(input string tag);
    checkOutput({tag, "_busy_cycles"}, 64'(busyCycles), 64'(BUSY_EXPECTED));
    checkOutput({tag, "_done_pulses"}, 64'(doneCount), 64'd1);
    checkOutput({tag, "_stb_rises"}, 64'(stbRises), 64'd1);
    checkOutput({tag, "_cmd_bits"}, 64'(cmdBitsSeen), 64'd8);
    checkOutput({tag, "_cmd_queue_drained"}, 64'(cmdQ.size()), 64'd0);
  endtask

  // Directed sequence: reset, normal scans, ignored starts, mid-read reset.
  initial begin
    repeat (3) @(negedge i_clk);
    checkOutput("reset_outputs",
                {24'h0, o_busy, o_done, o_stb_n, o_sclk, o_dio_out, o_dio_oe, o_scan, o_keys},
                {24'h0, 6'b001110, 32'h0, 8'h0});
    i_rst_n = 1'b1;
    repeat (2) stepCycle();

    $display("[TB] scan with bytes 01,00,00,10");
    applyStimulus(32'h1000_0001, 1'b1);
    waitDone(-1, 1'b0);
    checkTransaction("pattern1");
    checkOutput("pattern1_keys_direct", 64'(o_keys), 64'h81);

    $display("[TB] all-ones scan followed by all-zeros scan");
    applyStimulus(32'hFFFF_FFFF, 1'b1);
    waitDone(-1, 1'b0);
    checkTransaction("ones");
    checkOutput("ones_keys_direct", 64'(o_keys), 64'hFF);
    applyStimulus(32'h0000_0000, 1'b1);
    waitDone(-1, 1'b0);
    checkTransaction("zeros");
    checkOutput("zeros_scan_direct", 64'(o_scan), 64'h0);

    $display("[TB] start during READ and on the done cycle");
    applyStimulus(32'h1234_5678, 1'b1);
    waitDone(100, 1'b1);
    repeat (20) stepCycle();
    checkTransaction("ignored_start");
    checkOutput("ignored_start_scan_held", 64'(o_scan), 64'h1234_5678);

    $display("[TB] reset in the middle of READ");
    applyStimulus(32'h5555_AAAA, 1'b0);
    repeat (80) stepCycle();
    @(negedge i_clk);
    i_rst_n = 1'b0;
    #1;
    checkOutput("midreset_pins",
                {59'h0, o_stb_n, o_sclk, o_dio_oe, o_busy, o_done},
                {59'h0, 5'b11000});
    checkOutput("midreset_scan", 64'(o_scan), 64'h0);
    repeat (2) stepCycle();
    i_rst_n = 1'b1;
    cmdQ.delete();
    repeat (200) stepCycle();
    checkOutput("midreset_no_done", 64'(doneCount), 64'd0);
    checkOutput("midreset_scan_kept_zero", 64'(o_scan), 64'h0);
    checkOutput("midreset_busy_idle", 64'(o_busy), 64'd0);

    $display("[TB] fresh scan after reset");
    applyStimulus(32'hA5C3_0F96, 1'b1);
    waitDone(-1, 1'b0);
    checkTransaction("after_reset");
    checkOutput("scoreboard_drained", 64'(scanQ.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
